// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO bus controller: arbitrates instruction fetch against the
// load/store buffer and sequences each multi-byte request as byte accesses.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h00030000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic [1:0]  dbg_state
);

    // Handshake: a requester raises req (level) with stable addr/data and holds
    // it until its done pulse; the pulse cycle never grants, so req may drop then.
    typedef enum logic [1:0] {IDLE = 2'd0, IF_RD = 2'd1, LS_RD = 2'd2, LS_WR = 2'd3} state_t;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_LSB   = 1'b1;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  n_q;
    logic [2:0]  len_n;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        last_grant_q;
    logic        may_grant;
    logic        grant_if;
    logic        grant_ls;
    logic        io_stall;
    logic [1:0]  rd_lane;
    logic [1:0]  wr_lane_nxt;

    assign dbg_state   = state_q;
    assign io_stall    = (mem_a[17:16] == IO_BASE[17:16]) && io_buffer_full;
    assign mem_wr      = wr_q & rdy & ~io_stall;
    assign rd_lane     = cnt_q[1:0] - 2'd1;
    assign wr_lane_nxt = cnt_q[1:0] + 2'd1;

    always_comb begin
        case (lsb_len)
            2'd0:    len_n = 3'd1;
            2'd1:    len_n = 3'd2;
            default: len_n = 3'd4;
        endcase
    end

    // A done pulse still on the bus blocks granting so the finished requester can drop req.
    assign may_grant = (state_q == IDLE) && !clear && !if_done && !lsb_done;
    assign grant_if  = may_grant && if_req && (!lsb_req || last_grant_q == GRANT_LSB);
    assign grant_ls  = may_grant && lsb_req && (!if_req || last_grant_q == GRANT_FETCH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_if)      state_d = IF_RD;
                else if (grant_ls) state_d = lsb_wr ? LS_WR : LS_RD;
            end
            IF_RD, LS_RD: begin
                if (clear || cnt_q == n_q) state_d = IDLE;
            end
            LS_WR: begin
                if (!io_stall && cnt_q == n_q - 3'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 3'd0;
            n_q          <= 3'd0;
            wdata_q      <= 32'd0;
            wr_q         <= 1'b0;
            last_grant_q <= GRANT_FETCH;
            mem_a        <= 32'd0;
            mem_dout     <= 8'd0;
            if_done      <= 1'b0;
            lsb_done     <= 1'b0;
            if_data      <= 32'd0;
            lsb_rdata    <= 32'd0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_if) begin
                        n_q     <= 3'd4;
                        cnt_q   <= 3'd0;
                        mem_a   <= if_addr;
                        if_data <= 32'd0;
                    end else if (grant_ls) begin
                        n_q     <= len_n;
                        cnt_q   <= 3'd0;
                        mem_a   <= lsb_addr;
                        wdata_q <= lsb_wdata;
                        if (lsb_wr) begin
                            mem_dout <= lsb_wdata[7:0];
                            wr_q     <= 1'b1;
                        end else begin
                            lsb_rdata <= 32'd0;
                        end
                    end
                end
                IF_RD, LS_RD: begin
                    // Byte k on mem_din answers the address issued one cycle earlier.
                    if (!clear) begin
                        if (cnt_q != 3'd0) begin
                            if (state_q == IF_RD) if_data[{rd_lane, 3'b000} +: 8]   <= mem_din;
                            else                  lsb_rdata[{rd_lane, 3'b000} +: 8] <= mem_din;
                        end
                        if (cnt_q == n_q) begin
                            if (state_q == IF_RD) begin
                                if_done      <= 1'b1;
                                last_grant_q <= GRANT_FETCH;
                            end else begin
                                lsb_done     <= 1'b1;
                                last_grant_q <= GRANT_LSB;
                            end
                        end else begin
                            mem_a <= mem_a + 32'd1;
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                LS_WR: begin
                    if (!io_stall) begin
                        if (cnt_q == n_q - 3'd1) begin
                            wr_q         <= 1'b0;
                            lsb_done     <= 1'b1;
                            last_grant_q <= GRANT_LSB;
                        end else begin
                            cnt_q    <= cnt_q + 3'd1;
                            mem_a    <= mem_a + 32'd1;
                            mem_dout <= wdata_q[{wr_lane_nxt, 3'b000} +: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, per-scenario tasks and
// scoreboard queues for read words and write beats.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic [1:0]  dbg_state;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / RAM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [0:65535];

    // RAM shares the global enable, so a frozen cycle leaves mem_din unchanged.
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[15:0]];
    end

    // ---------------- scoreboard and logs ----------------
    logic [31:0] exp_q[$];      // expected read words
    logic [47:0] exp_w_q[$];    // {cycle, addr, data} expected write beats
    logic [47:0] obs_w_q[$];    // observed write beats

    int n_checks = 0;
    int n_fail   = 0;

    int rdy_lo, rdy_hi, iof_lo, iof_hi, clr_cyc;
    int if_done_cyc, if_done_cnt, lsb_done_cyc, lsb_done_cnt;
    logic [31:0] if_data_at, lsb_rdata_at;
    logic [31:0] ma_log [0:31];
    logic [1:0]  st_log [0:31];

    task automatic clear_sched();
        rdy_lo = -1; rdy_hi = -1; iof_lo = -1; iof_hi = -1; clr_cyc = -1;
    endtask

    // Watches ncyc cycles starting with the current one (cycle 0 = request first seen).
    task automatic watch(input int ncyc);
        if_done_cyc = -1; if_done_cnt = 0; lsb_done_cyc = -1; lsb_done_cnt = 0;
        obs_w_q.delete();
        for (int k = 0; k < ncyc; k++) begin
            rdy            = !(k >= rdy_lo && k <= rdy_hi);
            io_buffer_full = (k >= iof_lo && k <= iof_hi);
            clear          = (k == clr_cyc);
            if (k == clr_cyc) if_req = 1'b0;
            @(negedge clk);
            if (k < 32) begin
                ma_log[k] = mem_a;
                st_log[k] = dbg_state;
            end
            if (mem_wr) obs_w_q.push_back({8'(k), mem_a, mem_dout});
            if (if_done) begin
                if (if_done_cnt == 0) if_done_cyc = k;
                if_done_cnt++;
                if_data_at = if_data;
                if_req = 1'b0;
            end
            if (lsb_done) begin
                if (lsb_done_cnt == 0) lsb_done_cyc = k;
                lsb_done_cnt++;
                lsb_rdata_at = lsb_rdata;
                lsb_req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        rdy = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
        if_req = 1'b0; lsb_req = 1'b0;
        clear_sched();
    endtask

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) ram[16'(a + 32'(i))] = w[8*i +: 8];
    endtask

    task automatic start_lsb(input logic wr, input logic [31:0] a, input logic [1:0] len,
                             input logic [31:0] wd);
        lsb_wr = wr; lsb_addr = a; lsb_len = len; lsb_wdata = wd; lsb_req = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_a, mem_dout, mem_wr, if_done, lsb_done, dbg_state} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: mem_a=%h dout=%h wr=%b ifd=%b lsd=%b st=%0d, required all zero",
                     mem_a, mem_dout, mem_wr, if_done, lsb_done, dbg_state);
        end
        n_checks++;
        if (if_data !== 32'd0 || lsb_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: if_data=%h lsb_rdata=%h, required 0", if_data, lsb_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        logic [31:0] e;
        ram[16'h0010] = 8'h80;
        put_word(32'h2000, 32'h11223344);
        if_addr = 32'h2000; if_req = 1'b1;
        start_lsb(1'b0, 32'h10, 2'd0, 32'd0);
        exp_q.push_back(32'h00000080);
        exp_q.push_back(32'h11223344);
        watch(14);
        n_checks++;
        if (lsb_done_cyc != 3) begin
            n_fail++; $display("FAIL tie_lsb_first: lsb_done cycle %0d, required 3", lsb_done_cyc);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (lsb_rdata_at !== e) begin
            n_fail++; $display("FAIL tie_lsb_data: got %h, required %h", lsb_rdata_at, e);
        end
        n_checks++;
        if (ma_log[5] !== 32'h2000 || if_done_cyc != 10) begin
            n_fail++;
            $display("FAIL tie_fetch_after: mem_a@5=%h if_done cycle %0d, required 2000 and 10",
                     ma_log[5], if_done_cyc);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (if_data_at !== e) begin
            n_fail++; $display("FAIL tie_fetch_data: got %h, required %h", if_data_at, e);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] e;
        put_word(32'h1000, 32'h00000513);
        if_addr = 32'h1000; if_req = 1'b1;
        exp_q.push_back(32'h00000513);
        watch(10);
        e = exp_q.pop_front();
        n_checks++;
        if (if_done_cyc != 6 || if_done_cnt != 1) begin
            n_fail++;
            $display("FAIL fetch_timing: if_done cycle %0d count %0d, required 6 and 1", if_done_cyc, if_done_cnt);
        end
        n_checks++;
        if (if_data_at !== e) begin
            n_fail++; $display("FAIL fetch_data: got %h, required %h", if_data_at, e);
        end
        n_checks++;
        if (ma_log[1] !== 32'h1000 || ma_log[4] !== 32'h1003) begin
            n_fail++;
            $display("FAIL fetch_addr: mem_a@1=%h @4=%h, required 1000 and 1003", ma_log[1], ma_log[4]);
        end
        n_checks++;
        if (obs_w_q.size() != 0) begin
            n_fail++; $display("FAIL fetch_no_write: %0d write beats, required 0", obs_w_q.size());
        end
    endtask

    task automatic check_writes(input string name);
        int ne;
        ne = exp_w_q.size();
        n_checks++;
        if (obs_w_q.size() != ne) begin
            n_fail++;
            $display("FAIL %s_beats: %0d write beats, required %0d", name, obs_w_q.size(), ne);
        end
        for (int i = 0; i < ne; i++) begin
            logic [47:0] e, o;
            e = exp_w_q.pop_front();
            o = (obs_w_q.size() > 0) ? obs_w_q.pop_front() : 48'hFFFF_FFFF_FFFF;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s_beat%0d: cyc=%0d a=%h d=%h, required cyc=%0d a=%h d=%h",
                         name, i, o[47:40], o[39:8], o[7:0], e[47:40], e[39:8], e[7:0]);
            end
        end
    endtask

    task automatic test_store();
        start_lsb(1'b1, 32'h200, 2'd2, 32'hDEADBEEF);
        exp_w_q.push_back({8'd1, 32'h200, 8'hEF});
        exp_w_q.push_back({8'd2, 32'h201, 8'hBE});
        exp_w_q.push_back({8'd3, 32'h202, 8'hAD});
        exp_w_q.push_back({8'd4, 32'h203, 8'hDE});
        watch(8);
        check_writes("store");
        n_checks++;
        if (lsb_done_cyc != 5 || lsb_done_cnt != 1) begin
            n_fail++;
            $display("FAIL store_done: cycle %0d count %0d, required 5 and 1", lsb_done_cyc, lsb_done_cnt);
        end
    endtask

    // The store just finished, so the fetch now wins the tie.
    task automatic test_back_to_back();
        if_addr = 32'h1000; if_req = 1'b1;
        start_lsb(1'b0, 32'h10, 2'd0, 32'd0);
        watch(14);
        n_checks++;
        if (if_done_cyc != 6 || lsb_done_cyc != 10) begin
            n_fail++;
            $display("FAIL b2b_order: if_done %0d lsb_done %0d, required 6 and 10", if_done_cyc, lsb_done_cyc);
        end
        n_checks++;
        if (lsb_rdata_at !== 32'h80 || if_data_at !== 32'h513) begin
            n_fail++;
            $display("FAIL b2b_data: lsb=%h if=%h, required 00000080 and 00000513", lsb_rdata_at, if_data_at);
        end
    endtask

    task automatic test_flush_fetch();
        logic bad_idle;
        if_addr = 32'h1000; if_req = 1'b1;
        clr_cyc = 3;
        watch(10);
        bad_idle = 1'b0;
        for (int k = 4; k < 10; k++) if (st_log[k] !== 2'd0) bad_idle = 1'b1;
        n_checks++;
        if (if_done_cnt != 0) begin
            n_fail++; $display("FAIL flush_fetch_done: %0d pulses, required 0", if_done_cnt);
        end
        n_checks++;
        if (st_log[3] !== 2'd1 || bad_idle) begin
            n_fail++;
            $display("FAIL flush_fetch_idle: state@3=%0d state@4=%0d, required 1 then IDLE", st_log[3], st_log[4]);
        end
    endtask

    task automatic test_flush_store();
        start_lsb(1'b1, 32'h300, 2'd1, 32'h1234A55A);
        clr_cyc = 1;
        exp_w_q.push_back({8'd1, 32'h300, 8'h5A});
        exp_w_q.push_back({8'd2, 32'h301, 8'hA5});
        watch(7);
        check_writes("flush_store");
        n_checks++;
        if (lsb_done_cyc != 3) begin
            n_fail++; $display("FAIL flush_store_done: cycle %0d, required 3", lsb_done_cyc);
        end
    endtask

    task automatic test_io_stall();
        start_lsb(1'b1, 32'h30000, 2'd0, 32'h00000041);
        iof_lo = 1; iof_hi = 3;
        exp_w_q.push_back({8'd4, 32'h30000, 8'h41});
        watch(8);
        check_writes("io_stall");
        n_checks++;
        if (lsb_done_cyc != 5) begin
            n_fail++; $display("FAIL io_stall_done: cycle %0d, required 5", lsb_done_cyc);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] w, e;
        w = $urandom;
        put_word(32'h400, w);
        start_lsb(1'b0, 32'h400, 2'd2, 32'd0);
        exp_q.push_back(w);
        rdy_lo = 3; rdy_hi = 4;
        watch(12);
        e = exp_q.pop_front();
        n_checks++;
        if (lsb_rdata_at !== e) begin
            n_fail++; $display("FAIL freeze_data: got %h, required %h", lsb_rdata_at, e);
        end
        n_checks++;
        if (lsb_done_cyc != 8 || obs_w_q.size() != 0) begin
            n_fail++;
            $display("FAIL freeze_timing: done %0d writes %0d, required 8 and 0", lsb_done_cyc, obs_w_q.size());
        end
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 8; it++) begin
            logic [31:0] a, w, e;
            logic [1:0]  len;
            int          n;
            a   = 32'h800 + 32'($urandom_range(0, 32'h700));
            len = 2'($urandom_range(0, 2));
            n   = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
            w   = $urandom;
            put_word(a, w);
            e = (n == 1) ? {24'd0, w[7:0]} : (n == 2) ? {16'd0, w[15:0]} : w;
            exp_q.push_back(e);
            start_lsb(1'b0, a, len, 32'd0);
            watch(n + 5);
            e = exp_q.pop_front();
            n_checks++;
            if (lsb_rdata_at !== e || lsb_done_cyc != n + 2) begin
                n_fail++;
                $display("FAIL rand_load%0d: data %h done %0d, required %h at %0d",
                         it, lsb_rdata_at, lsb_done_cyc, e, n + 2);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0; lsb_len = 2'd0; lsb_wdata = 32'd0;
        clear_sched();
        test_reset();
        test_tie();
        test_fetch();
        test_store();
        test_back_to_back();
        test_flush_fetch();
        test_flush_store();
        test_io_stall();
        test_freeze();
        test_random_loads();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter sharing the byte-wide RAM/IO bus between instruction fetch and the load/store buffer (LSB). It accepts one multi-byte request at a time and sequences it as consecutive byte accesses. Read bytes are assembled little-endian, and write bytes are streamed out. On a `clear` from the RoB, speculative fetches and loads are aborted. Committed stores always run to completion.

## Interface
- `IO_BASE`, default 32'h00030000: addresses with `addr[17:16]==2'b11` are IO and are subject to `io_buffer_full` stalls.
- `clk` input 1: system clock. Reset is synchronous and active-high.
- `rst` input 1: reset.
- `rdy` input 1: global enable. When low, all state is held.
- `clear` input 1: RoB mispredict flush.
- `if_req` input 1: fetch request. It is a level signal held until `if_done`.
- `if_addr` input 32: fetch address. A fetch is always 4 bytes.
- `if_done` output 1: one-cycle pulse when `if_data` is valid.
- `if_data` output 32: fetched word.
- `lsb_req` input 1: LSB request. It is a level signal held until `lsb_done`.
- `lsb_wr` input 1: 1 means store, 0 means load.
- `lsb_addr` input 32: byte address.
- `lsb_len` input 2: access size. 0 is a byte, 1 is a half-word, 2 is a word. Value 3 is illegal.
- `lsb_wdata` input 32: store data. Only the low `n` bytes are used.
- `lsb_done` output 1: one-cycle pulse when the operation completes.
- `lsb_rdata` output 32: load data, zero-extended. Sign extension is the LSB's job.
- `mem_din` input 8: RAM read data.
- `mem_dout` output 8: RAM write data.
- `mem_a` output 32: RAM address.
- `mem_wr` output 1: write strobe.
- `io_buffer_full` input 1: UART buffer full.

## Operation
- FSM states:
  - IDLE
  - IF_RD
  - LS_RD
  - LS_WR
- Byte count: `n` = 4 for fetch; `n` = 1, 2 or 4 for `lsb_len` = 0, 1, 2.
- Arbitration in IDLE:
  - Only one requester pending: it is granted.
  - Both pending: the requester not granted last is granted.
  - `last_grant` resets to FETCH, so LSB wins the first tie.
- IDLE does not grant in a cycle where `if_done` or `lsb_done` is high. This gives the requester time to drop `req`.
- Grant cycle actions: latch `addr`, `n` and `wdata`; clear the byte counter and data register; load `mem_a <= addr`.
- Reads (IF_RD, LS_RD):
  - `mem_a` steps `addr`, `addr+1`, ..., `addr+n-1` on consecutive cycles.
  - Byte `k` arrives on `mem_din` one cycle after `mem_a = addr+k` and is stored in data bits `[8k+7:8k]`.
- Writes (LS_WR):
  - For each byte `k`, drive `mem_a = addr+k`, `mem_dout = wdata[8k+7:8k]` and `mem_wr = 1` for exactly one cycle.
  - IO stall: if the address is IO and `io_buffer_full = 1`, hold `mem_wr = 0`, keep `mem_a`, and retry the same byte the next cycle.
- Completion: after the last byte, pulse the matching `done`, return to IDLE, and update `last_grant`.
- Address arithmetic is 32-bit and wraps modulo 2^32. No alignment is checked.
- `clear` (sampled only when `rdy = 1`):
  - In IF_RD or LS_RD: go to IDLE next cycle, no `done` pulse, `mem_a` and data discarded.
  - In LS_WR: ignored; the store completes.
  - In IDLE: no grant that cycle.
  - A `done` that would be pulsed in the same cycle as `clear` during a read is suppressed.
- `rdy = 0`:
  - All registers hold.
  - `mem_wr` is forced to 0 combinationally (`mem_wr = wr_q & rdy`).
  - The pending byte is re-driven once `rdy` returns.
- Reset values: state IDLE, `mem_a = 0`, `mem_dout = 0`, `mem_wr = 0`, `if_done = 0`, `lsb_done = 0`, `if_data = 0`, `lsb_rdata = 0`, counter 0, `last_grant = FETCH`.
- `rst` mid-transaction aborts it unconditionally, including stores.

## Timing
- Request first seen in IDLE in cycle t, no stalls:
  - Read: `mem_a = addr` at t+1; bytes on `mem_din` at t+2 … t+n+1; `done` pulses and data is valid at t+n+2. A 4-byte fetch therefore gives `done` at t+6.
  - Write: `mem_wr = 1` at t+1 … t+n; `done` at t+n+1.
- Each `rdy = 0` cycle or IO stall cycle adds one cycle of latency.
- `if_data` and `lsb_rdata` hold their value until the next grant of the same port.
- Back-to-back: the earliest next grant is the cycle after `done`.

## Test plan
- Fetch: `if_addr = 0x1000`, RAM holds 13 05 00 00 → `if_data = 0x00000513`, `if_done` at t+6 for one cycle, `mem_wr` never 1.
- Word store: `0xDEADBEEF` at `0x200` → `mem_wr` high t+1..t+4 at addresses `0x200`..`0x203` with `mem_dout` EF, BE, AD, DE; `lsb_done` at t+5.
- Tie: `if_req` and `lsb_req` rise together, LSB doing a byte load of `0x10` where RAM holds 0x80 → LSB served first, `lsb_rdata = 0x00000080`; the fetch is granted the cycle after `lsb_done`.
- Flush: `clear` at t+3 during a fetch → no `if_done` and IDLE at t+4. `clear` during a half-word store → both bytes are written and `lsb_done` still pulses.
- IO stall: byte store of 0x41 to `0x30000` with `io_buffer_full = 1` for cycles t+1..t+3 → `mem_wr = 0` through t+3, a single write cycle at t+4, `lsb_done` at t+5.
- Freeze: `rdy = 0` for 2 cycles in the middle of a word load → same `lsb_rdata`, `lsb_done` 2 cycles late, no extra `mem_wr`.
